// File: rtl/stage_wb_if.sv
// Writeback stage bus: MEM-stage payload, pipeline controls, decode read ports
// and the writeback results exported to hazard/forwarding logic.
interface stage_wb_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  logic              stall_WB;
  logic              flush_WB;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] alu_result_in;
  logic              ResultSrc_in;
  logic              RegWrite_in;
  logic [ADDR_W-1:0] rd_in;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [DATA_W-1:0] wb_result;
  logic [ADDR_W-1:0] wb_rd;
  logic              wb_regwrite;

  // Upstream pipeline / decode side
  modport master (
    output stall_WB, flush_WB, mem_data_in, alu_result_in, ResultSrc_in,
           RegWrite_in, rd_in, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_result, wb_rd, wb_regwrite
  );

  // Writeback stage side
  modport slave (
    input  stall_WB, flush_WB, mem_data_in, alu_result_in, ResultSrc_in,
           RegWrite_in, rd_in, rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_result, wb_rd, wb_regwrite
  );
endinterface

// File: rtl/stage_wb.sv
// Writeback stage: MEM/WB pipeline register, result select and the
// architectural register file with two write-through read ports.
// Optional macro WB_RETIRE_CNT_EN adds a saturating 16-bit retire counter.
module stage_wb #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 3,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  stage_wb_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [15:0] retire_cnt
`endif
);

  localparam int unsigned NREG = 2 ** ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic              result_src;
    logic              reg_write;
    logic [ADDR_W-1:0] rd;
  } memwb_t;

  memwb_t            q;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] result_c;
  logic              regwrite_c;

  // MEM/WB register: flush inserts a bubble and wins over stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (bus.flush_WB || !bus.stall_WB) begin
      q.mem        <= bus.mem_data_in;
      q.alu        <= bus.alu_result_in;
      q.result_src <= bus.ResultSrc_in;
      q.reg_write  <= bus.RegWrite_in && !bus.flush_WB;
      q.rd         <= bus.rd_in;
    end
  end

  // Result select and effective write enable (r0 writes suppressed)
  always_comb begin
    result_c   = q.result_src ? q.mem : q.alu;
    regwrite_c = q.reg_write && !(R0_ZERO && (q.rd == '0));
  end

  assign bus.wb_result   = result_c;
  assign bus.wb_rd       = q.rd;
  assign bus.wb_regwrite = regwrite_c;

  // Register file commit; a stalled entry rewrites the same value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[ADDR_W'(i)] <= '0;
      end
    end else if (regwrite_c) begin
      regs[q.rd] <= result_c;
    end
  end

  // Read port 1: r0 forced to zero, then bypass, then array
  always_comb begin
    bus.rs1_data = regs[bus.rs1_addr];
    if (regwrite_c && (q.rd == bus.rs1_addr)) begin
      bus.rs1_data = result_c;
    end
    if (R0_ZERO && (bus.rs1_addr == '0)) begin
      bus.rs1_data = '0;
    end
  end

  // Read port 2: same priority as port 1, evaluated independently
  always_comb begin
    bus.rs2_data = regs[bus.rs2_addr];
    if (regwrite_c && (q.rd == bus.rs2_addr)) begin
      bus.rs2_data = result_c;
    end
    if (R0_ZERO && (bus.rs2_addr == '0)) begin
      bus.rs2_data = '0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  // Count unstalled retiring writes, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
    end else if (regwrite_c && !bus.stall_WB && (retire_cnt != 16'hFFFF)) begin
      retire_cnt <= retire_cnt + 16'd1;
    end
  end
`endif

endmodule
